// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner; digits snapshotted once per frame, alarm blink.
// Outputs registered: an_n/seg_n/dp_n reflect the current slot one cycle later; no backpressure.
module clock_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 16,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hr_in_1,
  input  logic [3:0] hr_in_0,
  input  logic [3:0] min_in_1,
  input  logic [3:0] min_in_0,
  input  logic [3:0] sec_in_1,
  input  logic [3:0] sec_in_0,
  input  logic       Alarm,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_strb
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [5:0][3:0]   snap_q, snap_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [5:0]        an_n_q, an_n_d;
  logic [6:0]        seg_n_q, seg_n_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_strb_q, frame_strb_d;

  logic       tick;
  logic       wrap;
  logic       blank;
  logic [3:0] digit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick          = (scan_cnt_q == SCAN_LAST);
    wrap          = tick && (idx_q == 3'd5);
    scan_cnt_d    = tick ? '0 : scan_cnt_q + 1'b1;
    idx_d         = idx_q;
    snap_d        = snap_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    frame_strb_d  = wrap;

    if (tick) begin
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    if (wrap) begin
      snap_d = {{2'b00, hr_in_1}, hr_in_0, min_in_1, min_in_0, sec_in_1, sec_in_0};
    end

    // Blink counting only runs while the alarm is up; dropping it restores display at once.
    if (!Alarm) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    case (idx_q)
      3'd0:    digit = snap_q[0];
      3'd1:    digit = snap_q[1];
      3'd2:    digit = snap_q[2];
      3'd3:    digit = snap_q[3];
      3'd4:    digit = snap_q[4];
      3'd5:    digit = snap_q[5];
      default: digit = 4'd0;
    endcase

    blank   = Alarm && blink_phase_q;
    seg_n_d = decode(digit);
    an_n_d  = ~(6'b000001 << idx_q);
    if (blank || (LZ_BLANK && (idx_q == 3'd5) && (digit == 4'd0))) begin
      an_n_d = 6'h3F;
    end
    dp_n_d = blank || !((idx_q == 3'd2) || (idx_q == 3'd4));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= 3'd0;
      snap_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_n_q        <= 6'h3F;
      seg_n_q       <= 7'h7F;
      dp_n_q        <= 1'b1;
      frame_strb_q  <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_n_q        <= an_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      frame_strb_q  <= frame_strb_d;
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_strb = frame_strb_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: frame-table vectors, hand sequences, and a cycle model.
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] hr_in_1;
  logic [3:0] hr_in_0, min_in_1, min_in_0, sec_in_1, sec_in_0;
  logic       Alarm;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;
  logic       frame_strb;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .hr_in_1(hr_in_1), .hr_in_0(hr_in_0), .min_in_1(min_in_1), .min_in_0(min_in_0),
    .sec_in_1(sec_in_1), .sec_in_0(sec_in_0), .Alarm(Alarm),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_strb(frame_strb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time since reset, digits held for the frame, frames of alarm so far.
  int m_t      = 0;
  int m_snap [6];
  int m_frames = 0;

  typedef struct {
    logic [1:0]      h1;
    logic [3:0]      h0, m1, m0, s1, s0;
    logic [5:0][6:0] seg;
    logic [5:0][5:0] an;
    logic [5:0]      dp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;  3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;  9: seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  // One clock: predict outputs from the model, advance the model, then compare.
  task automatic cycle();
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_strb, was_rst;
    int         idx, dg;
    bit         blank, wrap;
    was_rst = reset;
    wrap    = 1'b0;
    if (reset) begin
      e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1; e_strb = 1'b0;
      m_t = 0; m_frames = 0;
      for (int i = 0; i < 6; i++) m_snap[i] = 0;
    end else begin
      idx    = (m_t / SD) % 6;
      dg     = m_snap[idx];
      blank  = Alarm && (((m_frames / BF) % 2) == 1);
      e_an   = (blank || (idx == 5 && dg == 0)) ? 6'h3F : ~(6'(1) << idx);
      e_seg  = seg_of(dg);
      e_dp   = blank || !(idx == 2 || idx == 4);
      wrap   = (m_t % (6 * SD)) == (6 * SD - 1);
      e_strb = wrap;
      if (wrap) begin
        m_snap[0] = int'(sec_in_0); m_snap[1] = int'(sec_in_1);
        m_snap[2] = int'(min_in_0); m_snap[3] = int'(min_in_1);
        m_snap[4] = int'(hr_in_0);  m_snap[5] = int'(hr_in_1);
      end
      m_frames = Alarm ? m_frames + (wrap ? 1 : 0) : 0;
      m_t++;
    end
    @(posedge clk);
    #1;
    chk("model_an_n", an_n, e_an);
    if (was_rst || e_an != 6'h3F) chk("model_seg_n", seg_n, e_seg);
    chk("model_dp_n", dp_n, e_dp);
    chk("model_frame_strb", frame_strb, e_strb);
  endtask

  task automatic wait_strb();
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      cycle();
      got = (frame_strb === 1'b1);
    end
    chk("frame_strb_seen", got, 1);
  endtask

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                          input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
    hr_in_1 = h1; hr_in_0 = h0; min_in_1 = m1; min_in_0 = m0; sec_in_1 = s1; sec_in_0 = s0;
  endtask

  task automatic scramble();
    set_time(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom));
  endtask

  // Apply a time, wait for its capture, then check every slot for SD cycles each.
  // Inputs are changed mid-frame to confirm the display holds the captured digits.
  task automatic run_vec(input vec_t v);
    set_time(v.h1, v.h0, v.m1, v.m0, v.s1, v.s0);
    wait_strb();
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < SD; k++) begin
        if (s == 3 && k == 0) scramble();
        cycle();
        chk($sformatf("tbl_an_slot%0d", s), an_n, v.an[s]);
        if (v.an[s] != 6'h3F) chk($sformatf("tbl_seg_slot%0d", s), seg_n, v.seg[s]);
        chk($sformatf("tbl_dp_slot%0d", s), dp_n, v.dp[s]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{h1: 2'd1, h0: 4'd2, m1: 4'd3, m0: 4'd4, s1: 4'd5, s0: 4'd6,
                seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010},
                an: {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E}, dp: 6'b101011};
    vecs[1] = '{h1: 2'd0, h0: 4'd9, m1: 4'd0, m0: 4'd0, s1: 4'd0, s0: 4'd0,
                seg: {7'b1000000, 7'b0010000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000},
                an: {6'h3F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E}, dp: 6'b101011};
    vecs[2] = '{h1: 2'd2, h0: 4'd3, m1: 4'd5, m0: 4'hC, s1: 4'd5, s0: 4'd9,
                seg: {7'b0100100, 7'b0110000, 7'b0010010, 7'b0111111, 7'b0010010, 7'b0010000},
                an: {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E}, dp: 6'b101011};
    vecs[3] = '{h1: 2'd1, h0: 4'd8, m1: 4'd0, m0: 4'd7, s1: 4'd0, s0: 4'hA,
                seg: {7'b1111001, 7'b0000000, 7'b1000000, 7'b1111000, 7'b1000000, 7'b0111111},
                an: {6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E}, dp: 6'b101011};

    reset = 1'b1; Alarm = 1'b0;
    set_time(2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_an_n", an_n, 6'h3F);
      chk("rst_seg_n", seg_n, 7'h7F);
      chk("rst_dp_n", dp_n, 1);
      chk("rst_frame_strb", frame_strb, 0);
    end
    reset = 1'b0;
    set_time(2'd2, 4'd1, 4'd4, 4'd7, 4'd3, 4'd8);
    for (int i = 0; i < SD; i++) begin
      cycle();
      chk("first_frame_an_n", an_n, 6'h3E);
      chk("first_frame_seg_n", seg_n, 7'b1000000);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // Alarm: two visible frames, then two dark ones; drop it while dark.
    set_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    wait_strb();
    Alarm = 1'b1;
    wait_strb();
    wait_strb();
    cycle();
    chk("alarm_dark_an_n", an_n, 6'h3F);
    chk("alarm_dark_dp_n", dp_n, 1);
    for (int i = 0; i < 4; i++) cycle();
    chk("alarm_still_dark", an_n, 6'h3F);
    Alarm = 1'b0;
    begin
      bit vis = 1'b0;
      for (int i = 0; i < 2 && !vis; i++) begin
        cycle();
        vis = (an_n !== 6'h3F);
      end
      chk("alarm_drop_visible", vis, 1);
    end

    // Randomised run with occasional alarm toggles and input changes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) scramble();
      if ($urandom_range(0, 79) == 0) Alarm = ~Alarm;
      cycle();
    end
    Alarm = 1'b0;

    // Reset mid-frame at slot 3 drops the snapshot.
    set_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    wait_strb();
    begin
      bit at3 = 1'b0;
      for (int i = 0; i < 40 && !at3; i++) begin
        cycle();
        at3 = (((m_t / SD) % 6) == 3) && ((m_t % SD) == 1);
      end
      chk("reach_slot3", at3, 1);
    end
    reset = 1'b1;
    cycle();
    chk("midrst_an_n", an_n, 6'h3F);
    chk("midrst_seg_n", seg_n, 7'h7F);
    reset = 1'b0;
    for (int i = 0; i < SD; i++) begin
      cycle();
      chk("post_rst_an_n", an_n, 6'h3E);
      chk("post_rst_seg_n", seg_n, 7'b1000000);
    end
    cycle();
    chk("post_rst_slot1_an_n", an_n, 6'h3D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
